// File: rtl/regfile_ctrl.sv
// regfile_ctrl -- initiator-side command sequencer for the `registerfile` block.
//
// After reset it writes zero to every register (CLEAR). It then accepts single
// read/write commands over a valid/ready handshake and turns them into
// registerfile EN/WR/RD strobes, select lines and write data. The two
// read-port results are captured and returned over a valid/ready response
// channel.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake (ready only in IDLE)
//   cmd_wr                   1 = write, 0 = read
//   cmd_addr_a               write address, or port-1 read address
//   cmd_addr_b               port-2 read address (ignored for writes)
//   cmd_wdata                write data
//   rsp_valid/rsp_ready      read-response handshake
//   rsp_data_a/rsp_data_b    captured rf_op1 / rf_op2
//   busy                     high in any state other than IDLE
//   rf_en, rf_wr, rf_rd      registerfile EN / WR / RD
//   rf_sel_i1                registerfile write select
//   rf_sel_o1, rf_sel_o2     registerfile read selects
//   rf_ip1                   registerfile write data
//   rf_op1, rf_op2           registerfile read data
module regfile_ctrl #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 4,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr_a,
  input  logic [AW-1:0] cmd_addr_b,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data_a,
  output logic [DW-1:0] rsp_data_b,
  output logic          busy,
  output logic          rf_en,
  output logic          rf_wr,
  output logic          rf_rd,
  output logic [AW-1:0] rf_sel_i1,
  output logic [AW-1:0] rf_sel_o1,
  output logic [AW-1:0] rf_sel_o2,
  output logic [DW-1:0] rf_ip1,
  input  logic [DW-1:0] rf_op1,
  input  logic [DW-1:0] rf_op2
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_WRITE,
    S_READ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state_q;
  logic [AW-1:0] k_q;
  logic [3:0]    wcnt_q;
  logic [AW-1:0] addr_a_q;
  logic [AW-1:0] addr_b_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rsp_a_q;
  logic [DW-1:0] rsp_b_q;

  // Select/data lines keep their last driven value: each has a hold register
  // that follows whatever the current state drives.
  logic [AW-1:0] sel_i1_q, sel_i1_d;
  logic [AW-1:0] sel_o1_q, sel_o1_d;
  logic [AW-1:0] sel_o2_q, sel_o2_d;
  logic [DW-1:0] ip1_q,    ip1_d;

  always_comb begin
    sel_i1_d = sel_i1_q;
    sel_o1_d = sel_o1_q;
    sel_o2_d = sel_o2_q;
    ip1_d    = ip1_q;
    case (state_q)
      S_CLEAR: begin
        sel_i1_d = k_q;
        ip1_d    = '0;
      end
      S_WRITE: begin
        sel_i1_d = addr_a_q;
        ip1_d    = wdata_q;
      end
      S_READ: begin
        sel_o1_d = addr_a_q;
        sel_o2_d = addr_b_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_CLEAR;
      k_q      <= '0;
      wcnt_q   <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      wdata_q  <= '0;
      rsp_a_q  <= '0;
      rsp_b_q  <= '0;
      sel_i1_q <= '0;
      sel_o1_q <= '0;
      sel_o2_q <= '0;
      ip1_q    <= '0;
    end else begin
      sel_i1_q <= sel_i1_d;
      sel_o1_q <= sel_o1_d;
      sel_o2_q <= sel_o2_d;
      ip1_q    <= ip1_d;
      case (state_q)
        S_CLEAR: begin
          // k wraps back to 0 exactly as the state is left
          k_q <= k_q + 1'b1;
          if (k_q == '1) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (cmd_valid) begin
            addr_a_q <= cmd_addr_a;
            addr_b_q <= cmd_addr_b;
            wdata_q  <= cmd_wdata;
            state_q  <= cmd_wr ? S_WRITE : S_READ;
          end
        end
        S_WRITE: state_q <= S_IDLE;
        S_READ: begin
          wcnt_q  <= 4'(RD_LAT);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          wcnt_q <= wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) begin
            rsp_a_q <= rf_op1;
            rsp_b_q <= rf_op2;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  // The state register sits in CLEAR throughout reset, so the CLEAR-state
  // strobes and busy are gated by rst to stay low until reset is released.
  assign cmd_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_data_a = rsp_a_q;
  assign rsp_data_b = rsp_b_q;
  assign busy       = rst & (state_q != S_IDLE);
  assign rf_en      = rst & (state_q != S_IDLE) & (state_q != S_RESP);
  assign rf_wr      = rst & ((state_q == S_CLEAR) | (state_q == S_WRITE));
  assign rf_rd      = (state_q == S_READ);
  assign rf_sel_i1  = sel_i1_d;
  assign rf_sel_o1  = sel_o1_d;
  assign rf_sel_o2  = sel_o2_d;
  assign rf_ip1     = ip1_d;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: a registerfile model (one-edge read latency) hangs
// off the rf_* port; an array of expected register contents is maintained at
// command level and used to predict every read response.
module tb_regfile_ctrl;

  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 4;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned NREG   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr_a;
  logic [AW-1:0] cmd_addr_b;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data_a;
  logic [DW-1:0] rsp_data_b;
  logic          busy;
  logic          rf_en;
  logic          rf_wr;
  logic          rf_rd;
  logic [AW-1:0] rf_sel_i1;
  logic [AW-1:0] rf_sel_o1;
  logic [AW-1:0] rf_sel_o2;
  logic [DW-1:0] rf_ip1;
  logic [DW-1:0] rf_op1;
  logic [DW-1:0] rf_op2;

  regfile_ctrl #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b),
    .busy(busy), .rf_en(rf_en), .rf_wr(rf_wr), .rf_rd(rf_rd),
    .rf_sel_i1(rf_sel_i1), .rf_sel_o1(rf_sel_o1), .rf_sel_o2(rf_sel_o2),
    .rf_ip1(rf_ip1), .rf_op1(rf_op1), .rf_op2(rf_op2)
  );

  always #5 clk = ~clk;

  // registerfile model; while the controller is in reset its contents are
  // scrambled so that only the CLEAR pass can make them zero again.
  logic [DW-1:0] rf_mem [NREG];
  always @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < NREG; j++) rf_mem[j] <= $urandom;
    end else begin
      if (rf_en && rf_wr) rf_mem[rf_sel_i1] <= rf_ip1;
      if (rf_en && rf_rd) begin
        rf_op1 <= rf_mem[rf_sel_o1];
        rf_op2 <= rf_mem[rf_sel_o2];
      end
    end
  end

  logic [DW-1:0] ref_mem [NREG];
  int n_assert = 0;
  int n_fail = 0;
  int accept_cnt = 0;
  int rsp_xfer_cnt = 0;
  int overlap_cnt = 0;

  always @(posedge clk) begin
    if (rst && cmd_valid && cmd_ready) accept_cnt++;
    if (rst && rsp_valid && rsp_ready) rsp_xfer_cnt++;
  end
  always @(negedge clk) if (rf_wr && rf_rd) overlap_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge where rst is released; ends at cycle 16 (+1).
  task automatic check_clear();
    for (int i = 0; i < NREG; i++) begin
      #1;
      chk("clr_wr", 32'(rf_wr), 32'd1);
      chk("clr_en", 32'(rf_en), 32'd1);
      chk("clr_sel", 32'(rf_sel_i1), 32'(i));
      chk("clr_ip1", rf_ip1, 32'd0);
      chk("clr_ready", 32'(cmd_ready), 32'd0);
      chk("clr_rspv", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    #1;
    chk("ready_c16", 32'(cmd_ready), 32'd1);
    chk("idle_wr", 32'(rf_wr), 32'd0);
    chk("idle_en", 32'(rf_en), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    for (int r = 0; r < NREG; r++) ref_mem[r] = '0;
  endtask

  task automatic wait_accept(input string tag);
    int start;
    int n;
    start = accept_cnt;
    n = 0;
    while (accept_cnt == start && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accepted"}, 32'(accept_cnt - start), 32'd1);
    cmd_valid  = 1'b0;
    cmd_wr     = 1'($urandom);
    cmd_addr_a = 4'($urandom_range(15));
    cmd_addr_b = 4'($urandom_range(15));
    cmd_wdata  = $urandom;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid  = 1'b1;
    cmd_wr     = 1'b1;
    cmd_addr_a = a;
    cmd_addr_b = 4'($urandom_range(15));
    cmd_wdata  = d;
    wait_accept("wr");
    #1;
    chk("wr_strobe", 32'(rf_wr), 32'd1);
    chk("wr_no_rd", 32'(rf_rd), 32'd0);
    chk("wr_sel", 32'(rf_sel_i1), 32'(a));
    chk("wr_data", rf_ip1, d);
    chk("wr_busy", 32'(busy), 32'd1);
    ref_mem[a] = d;
    @(negedge clk);
    #1;
    chk("wr_back_idle", 32'(cmd_ready), 32'd1);
    chk("wr_no_rsp", 32'(rsp_valid), 32'd0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] b, input int hold);
    int edges;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    ea = ref_mem[a];
    eb = ref_mem[b];
    cmd_valid  = 1'b1;
    cmd_wr     = 1'b0;
    cmd_addr_a = a;
    cmd_addr_b = b;
    cmd_wdata  = $urandom;
    rsp_ready  = (hold == 0);
    wait_accept("rd");
    #1;
    chk("rd_strobe", 32'(rf_rd), 32'd1);
    chk("rd_no_wr", 32'(rf_wr), 32'd0);
    chk("rd_sel_o1", 32'(rf_sel_o1), 32'(a));
    chk("rd_sel_o2", 32'(rf_sel_o2), 32'(b));
    edges = 1;
    while (!rsp_valid && edges < 40) begin
      @(negedge clk);
      #1;
      edges++;
    end
    chk("rd_latency", 32'(edges), 32'(2 + RD_LAT));
    chk("rd_data_a", rsp_data_a, ea);
    chk("rd_data_b", rsp_data_b, eb);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data_a", rsp_data_a, ea);
      chk("hold_data_b", rsp_data_b, eb);
      chk("hold_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rsp_done_valid", 32'(rsp_valid), 32'd0);
    chk("rsp_done_ready", 32'(cmd_ready), 32'd1);
    chk("rsp_keep_a", rsp_data_a, ea);
  endtask

  initial begin
    int xfer_snap;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    rst        = 1'b0;
    cmd_valid  = 1'b0;
    cmd_wr     = 1'b0;
    cmd_addr_a = '0;
    cmd_addr_b = '0;
    cmd_wdata  = '0;
    rsp_ready  = 1'b1;
    #2;
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rspv", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_en", 32'(rf_en), 32'd0);
    chk("rst_wr", 32'(rf_wr), 32'd0);
    chk("rst_rd", 32'(rf_rd), 32'd0);
    chk("rst_data_a", rsp_data_a, 32'd0);
    chk("rst_data_b", rsp_data_b, 32'd0);
    chk("rst_ip1", rf_ip1, 32'd0);

    // A write held pending across the whole CLEAR pass
    cmd_valid  = 1'b1;
    cmd_wr     = 1'b1;
    cmd_addr_a = 4'd3;
    cmd_wdata  = 32'h5A5A1234;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    check_clear();
    chk("no_early_accept", 32'(accept_cnt), 32'd0);
    do_write(4'd3, 32'h5A5A1234);
    repeat (3) @(negedge clk);
    chk("accept_once", 32'(accept_cnt), 32'd1);

    do_read(4'd5, 4'd15, 0);
    do_write(4'd0, 32'hABCDEFAB);
    do_write(4'd1, 32'h01234567);
    do_read(4'd0, 4'd1, 0);
    do_read(4'd1, 4'd0, 5);
    do_read(4'd3, 4'd3, 0);

    for (int t = 0; t < 40; t++) begin
      ra = 4'($urandom_range(15));
      rb = ($urandom_range(3) == 0) ? ra : 4'($urandom_range(15));
      if ($urandom_range(1) == 1) do_write(ra, $urandom);
      else do_read(ra, rb, int'($urandom_range(3)));
    end

    // Reset during WAIT: the read is dropped and CLEAR reruns from k=0
    do_write(4'd7, 32'hCAFEF00D);
    cmd_valid  = 1'b1;
    cmd_wr     = 1'b0;
    cmd_addr_a = 4'd7;
    cmd_addr_b = 4'd3;
    rsp_ready  = 1'b1;
    wait_accept("rd_abort");
    @(negedge clk);
    xfer_snap = rsp_xfer_cnt;
    rst = 1'b0;
    #1;
    chk("mid_rst_rspv", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_en", 32'(rf_en), 32'd0);
    chk("mid_rst_data_a", rsp_data_a, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    check_clear();
    chk("aborted_no_rsp", 32'(rsp_xfer_cnt - xfer_snap), 32'd0);
    do_read(4'd7, 4'd3, 1);

    chk("wr_rd_exclusive", 32'(overlap_cnt), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_ctrl.md
# regfile_ctrl

Command sequencer that drives the `registerfile` block from the initiator side. Accepts single read/write commands over a valid/ready handshake and converts them into `registerfile` port activity: EN, WR/RD strobes, select lines, and write data. Captures the two read-port results and returns them over a valid/ready response channel. After reset it zero-initialises all 16 registers before accepting commands.

## Interface

Parameters:
- `DW`, 32, data width; matches `registerfile` `Ip1`/`Op1`/`Op2`.
- `AW`, 4, register select width; `2**AW` registers.
- `RD_LAT`, 1, number of `clk` edges from the edge that samples `rf_rd` to `rf_op1`/`rf_op2` being valid. Legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_wr`  in  1  1 = write, 0 = read.
- `cmd_addr_a`  in  AW  write address (write) or port-1 read address (read).
- `cmd_addr_b`  in  AW  port-2 read address; ignored for writes.
- `cmd_wdata`  in  DW  write data.
- `rsp_valid`  out  1  read result available.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_data_a`, `rsp_data_b`  out  DW each  captured `rf_op1` and `rf_op2`.
- `busy`  out  1  high in any state other than IDLE.
- `rf_en`, `rf_wr`, `rf_rd`  out  1 each  to `registerfile` EN/WR/RD.
- `rf_sel_i1`, `rf_sel_o1`, `rf_sel_o2`  out  AW each  to `registerfile` select lines.
- `rf_ip1`  out  DW  to `registerfile` Ip1.
- `rf_op1`, `rf_op2`  in  DW each  from `registerfile` Op1/Op2.

## Operation

- States: CLEAR, IDLE, WRITE, READ, WAIT, RESP.
- Handshake: a command is accepted on a rising edge where `cmd_valid & cmd_ready`. `cmd_ready` = 1 only in IDLE. `cmd_*` fields are registered at acceptance.
- A response transfers on a rising edge where `rsp_valid & rsp_ready`.

State behaviour:
- **CLEAR**
  - Entered on reset; lasts `2**AW` cycles.
  - A 4-bit counter `k` runs 0..15.
  - Drives `rf_en=1`, `rf_wr=1`, `rf_sel_i1=k`, `rf_ip1=0`.
  - Goes to IDLE after `k=15`.
  - Any `cmd_valid` during CLEAR is ignored and stays pending.
- **IDLE**
  - `rf_en=rf_wr=rf_rd=0`.
  - On acceptance: go to WRITE if `cmd_wr=1`, else READ.
- **WRITE** (1 cycle)
  - Drives `rf_en=1`, `rf_wr=1`, `rf_sel_i1=addr_a`, `rf_ip1=wdata`.
  - Goes to IDLE. No response is generated for writes.
- **READ** (1 cycle)
  - Drives `rf_en=1`, `rf_rd=1`, `rf_sel_o1=addr_a`, `rf_sel_o2=addr_b`.
  - Loads wait counter with `RD_LAT`.
  - Goes to WAIT.
- **WAIT** (`RD_LAT` cycles)
  - Drives `rf_en=1`, `rf_rd=0`; `rf_sel_o*` held.
  - Counter decrements each cycle.
  - On the edge ending the last WAIT cycle: capture `rf_op1`→`rsp_data_a`, `rf_op2`→`rsp_data_b`, set `rsp_valid=1`, go to RESP.
- **RESP**
  - Holds `rsp_valid=1` and the data stable until `rsp_ready=1`.
  - On that edge: clear `rsp_valid`, go to IDLE.
  - `rsp_data_*` keep their last value after the transfer.

Output hold rules:
- `rf_sel_*` and `rf_ip1` hold their last driven value whenever they are not being driven by the current state.
- `rf_wr` and `rf_rd` are never 1 in the same cycle.

## Timing

Reset (`rst=0`, asynchronous):
- State goes to CLEAR with `k=0`.
- All outputs 0: `cmd_ready`, `rsp_valid`, `rsp_data_*`, `rf_*`, `busy`. While `rst=0`, `busy=0` and `rf_en=0`.
- First CLEAR write is driven in the first cycle after `rst` deasserts.

Reset mid-operation:
- Any in-flight command or pending response is dropped.
- `rsp_valid` goes to 0 immediately.
- CLEAR reruns in full after release.

Latency and throughput:
- `cmd_ready` first rises `2**AW` cycles after reset release (cycle 16 for AW=4).
- Write throughput: 1 command per 2 cycles (accept edge → WRITE → IDLE).
- Read latency: accept edge to `rsp_valid=1` is `2+RD_LAT` edges (3 for `RD_LAT=1`).
- Minimum read turnaround is `3+RD_LAT` cycles, with `rsp_ready` held at 1.

Boundary and legality rules:
- Read-after-write to the same address returns the new data, because the write completes before IDLE.
- `cmd_addr_a == cmd_addr_b` is legal; both outputs return the same value.
- The CLEAR counter wraps only through a state exit; it is never reused mid-state.

## Test plan

1. Reset release → `rf_wr=1` for exactly 16 consecutive cycles with `rf_sel_i1` = 0..15 and `rf_ip1=0`; `cmd_ready` rises on cycle 16.
2. Write `0xABCDEFAB`→r0, then `0x01234567`→r1; read (a=0, b=1) → `rsp_data_a=0xABCDEFAB`, `rsp_data_b=0x01234567`, `rsp_valid` 3 edges after acceptance.
3. After reset, read (a=5, b=15) → both outputs 0x00000000.
4. Read accepted with `rsp_ready=0` for 5 cycles → `rsp_valid` and data stable throughout; `cmd_ready=0` until 1 cycle after `rsp_ready` rises.
5. `cmd_valid` held high during CLEAR → no acceptance before cycle 16; then accepted exactly once.
6. `rst` pulsed low during WAIT → `rsp_valid` stays 0, no response is ever emitted for that read, and the CLEAR sequence restarts at `k=0`.
